cpl_tlp_assembler: RTL
======================

Name: cpl_tlp_assembler

Overview:
- Downstream stage of the completion header generator in the RX transaction layer.
- Buffers generated 3DW Completion-with-Data headers in a small FIFO. Pairs each header with its read-data beats from the memory read path.
- Emits a framed TLP stream (header beat, then payload beats) to the TX path.
- Provides sop/eop framing, a per-DW valid mask, and sticky error flags.

Parameters:
- HDR_WIDTH, 128, width of incoming header word; the 3DW header occupies [127:32].
- DATA_WIDTH, 256, payload/output beat width; DW_PER_BEAT = DATA_WIDTH/32 = 8.
- HDR_FIFO_DEPTH, 4, completion header FIFO entries; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cpl_hdr_wren  in  1  header write strobe, one cycle per header.
- cpl_hdr_data  in  HDR_WIDTH  {hdr96, 32'h0}; Length = cpl_hdr_data[105:96].
- hdr_fifo_full  out  1  header FIFO full; upstream uses it for stall.
- rdata_valid  in  1  read data beat valid.
- rdata_ready  out  1  read data beat accepted.
- rdata  in  DATA_WIDTH  read payload, DW0 in [31:0].
- rdata_last  in  1  last beat of this read.
- tlp_valid  out  1  output beat valid.
- tlp_ready  in  1  TX accepts beat.
- tlp_data  out  DATA_WIDTH  output beat.
- tlp_sop  out  1  header beat.
- tlp_eop  out  1  final beat of TLP.
- tlp_dwen  out  DW_PER_BEAT  valid-DW mask.
- hdr_overflow  out  1  sticky: header dropped on full FIFO.
- len_mismatch  out  1  sticky: rdata_last disagreed with header Length.

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied; FSM returns to IDLE.
  - Outputs go to 0: tlp_valid, tlp_sop, tlp_eop, tlp_dwen, tlp_data, rdata_ready, hdr_overflow, len_mismatch.
  - hdr_fifo_full=0.
  - A reset mid-TLP abandons that TLP; there is no resume.
- Header FIFO:
  - A write occurs on cpl_hdr_wren and not full.
  - Write while full, with no pop in the same cycle: header dropped, hdr_overflow set until reset.
  - Simultaneous push and pop while full: both occur, no overflow.
  - Pointers wrap modulo HDR_FIFO_DEPTH, with an extra bit for full/empty.
- FSM states: IDLE, HDR, DATA.
  - IDLE: when the FIFO is non-empty, latch Length from the head entry (len==0 means 1024 DW) into remaining[10:0], then go to HDR.
  - HDR:
    - Outputs: tlp_valid=1, tlp_sop=1, tlp_eop=0, tlp_data[95:0]=head[127:32], upper bits 0, tlp_dwen=8'b0000_0111. rdata_ready=0.
    - On tlp_ready, go to DATA.
  - DATA:
    - Combinational pass-through: tlp_valid=rdata_valid, rdata_ready=tlp_ready, tlp_data=rdata, tlp_sop=0.
    - Final beat is when remaining<=8. On it: tlp_eop=1, and tlp_dwen = low (remaining) bits set (8'hFF if remaining==8).
    - Non-final beats: tlp_dwen=8'hFF.
    - On each handshake, remaining -= 8.
    - On the final-beat handshake: pop the FIFO and go to IDLE.
- Latency: header written at cycle N into an idle, empty block gives the header beat valid at N+2. There is one idle bubble between consecutive TLPs.
- Output holding: tlp_data/tlp_valid must stay stable while tlp_valid && !tlp_ready. In HDR this comes from registers; in DATA it inherits upstream's AXI-style rule.
- len_mismatch is set when either occurs on a handshake:
  - rdata_last=1 on a non-final beat, or
  - rdata_last=0 on the final beat.
- The header Length count is always authoritative for framing.
- Arithmetic: remaining is 11 bits and never underflows (only decremented when >8).

Decomposition:
- PCIE_PKG additions:
  - CPL_LEN_MSB/LSB field positions.
  - DW_PER_BEAT.
  - Function dwen_from_remaining(remaining) returning the last-beat mask.
  - typedef cpl_asm_state_e {IDLE,HDR,DATA}.
- Sub-module: cpl_hdr_fifo (parameterised sync FIFO with full/empty, registered storage, combinational head read).

Test Plan:
- Len=8 header, one data beat with rdata_last=1 → header beat (sop, dwen=07) at N+2, then one beat with eop, dwen=FF; no errors.
- Len=13 → two data beats: dwen FF, then 1F with eop; FIFO empty afterward.
- Len=0 (1024 DW) → 128 data beats, eop only on the 128th, dwen FF.
- 5 back-to-back headers with tlp_ready=0 → hdr_fifo_full after 4, 5th dropped, hdr_overflow=1; release ready → exactly 4 TLPs emitted.
- Len=16 with rdata_last on beat 1 → len_mismatch=1, eop still on beat 2.
- rst asserted during the DATA beat of a 3-beat TLP → all outputs 0 immediately, FIFO empty, next header processed normally.
- tlp_ready toggling randomly during a Len=20 TLP → data/dwen stable while stalled, 3 data beats delivered in order.

Source files
------------

// File: rtl/cpl_tlp_assembler_pkg.sv
// +----------------------------------------------------------------------------
// | Module      : cpl_tlp_assembler_pkg
// | Description : Shared constants, state type and last-beat mask helper for
// |               the completion TLP assembler.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package cpl_tlp_assembler_pkg;

   localparam int CPL_LEN_MSB = 105;
   localparam int CPL_LEN_LSB = 96;
   localparam int HDR_LSB     = 32;
   localparam int DW_PER_BEAT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } cpl_asm_state_e;

   // Lowest 'remaining' DWs valid; saturates to all-ones at a full beat.
   function automatic logic [DW_PER_BEAT-1:0] dwen_from_remaining(input logic [10:0] remaining);
      logic [DW_PER_BEAT-1:0] mask;
      mask = '0;
      for (int i = 0; i < DW_PER_BEAT; i++) begin
         if (remaining > 11'(i)) mask[i] = 1'b1;
      end
      return mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpl_tlp_assembler_fifo.sv
// +----------------------------------------------------------------------------
// | Module      : cpl_hdr_fifo
// | Description : Small synchronous FIFO with registered storage and a
// |               combinational head read.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module cpl_hdr_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Extra MSB distinguishes full from empty when the indices coincide.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/cpl_tlp_assembler.sv
// +----------------------------------------------------------------------------
// | Module      : cpl_tlp_assembler
// | Description : Pairs queued 3DW completion headers with read-data beats and
// |               emits a framed TLP stream with sop/eop and a DW valid mask.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module cpl_tlp_assembler
   import cpl_tlp_assembler_pkg::*;
#(
   parameter int HDR_WIDTH      = 128,
   parameter int DATA_WIDTH     = 256,
   parameter int HDR_FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpl_hdr_wren,
   input  logic [HDR_WIDTH-1:0]   cpl_hdr_data,
   output logic                   hdr_fifo_full,
   input  logic                   rdata_valid,
   output logic                   rdata_ready,
   input  logic [DATA_WIDTH-1:0]  rdata,
   input  logic                   rdata_last,
   output logic                   tlp_valid,
   input  logic                   tlp_ready,
   output logic [DATA_WIDTH-1:0]  tlp_data,
   output logic                   tlp_sop,
   output logic                   tlp_eop,
   output logic [DW_PER_BEAT-1:0] tlp_dwen,
   output logic                   hdr_overflow,
   output logic                   len_mismatch
);

   localparam int HDR_BITS = HDR_WIDTH - HDR_LSB;

   cpl_asm_state_e state_q, state_d;
   logic [10:0]    remaining_q, remaining_d;
   logic           overflow_q, mismatch_q;

   logic [HDR_BITS-1:0] w_head;
   logic [9:0]          w_len;
   logic                w_full, w_empty, w_push, w_pop, w_drop, w_mismatch, w_final;
   logic                w_hdr_unused;

   assign w_hdr_unused = ^cpl_hdr_data[HDR_LSB-1:0];

   assign w_push = cpl_hdr_wren && (!w_full || w_pop);
   assign w_drop = cpl_hdr_wren && w_full && !w_pop;

   cpl_hdr_fifo #(
      .WIDTH (HDR_BITS),
      .DEPTH (HDR_FIFO_DEPTH)
   ) u_hdr_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push),
      .data_i  (cpl_hdr_data[HDR_WIDTH-1:HDR_LSB]),
      .pop_i   (w_pop),
      .head_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign w_len   = w_head[CPL_LEN_MSB-HDR_LSB:CPL_LEN_LSB-HDR_LSB];
   assign w_final = (remaining_q <= 11'd8);

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      tlp_valid   = 1'b0;
      tlp_sop     = 1'b0;
      tlp_eop     = 1'b0;
      tlp_dwen    = '0;
      tlp_data    = '0;
      rdata_ready = 1'b0;
      w_pop       = 1'b0;
      w_mismatch  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!w_empty) begin
               // A zero Length field encodes 1024 DW.
               remaining_d = {(w_len == 10'd0), w_len};
               state_d     = HDR;
            end
         end
         HDR: begin
            tlp_valid = 1'b1;
            tlp_sop   = 1'b1;
            tlp_data  = DATA_WIDTH'(w_head);
            tlp_dwen  = 8'b0000_0111;
            if (tlp_ready) state_d = DATA;
         end
         DATA: begin
            tlp_valid   = rdata_valid;
            rdata_ready = tlp_ready;
            tlp_data    = rdata;
            tlp_eop     = w_final;
            tlp_dwen    = w_final ? dwen_from_remaining(remaining_q) : '1;
            if (rdata_valid && tlp_ready) begin
               if (w_final) begin
                  w_pop      = 1'b1;
                  w_mismatch = !rdata_last;
                  state_d    = IDLE;
               end else begin
                  w_mismatch  = rdata_last;
                  remaining_d = remaining_q - 11'd8;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         overflow_q  <= 1'b0;
         mismatch_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         if (w_drop)     overflow_q <= 1'b1;
         if (w_mismatch) mismatch_q <= 1'b1;
      end
   end

   assign hdr_fifo_full = w_full;
   assign hdr_overflow  = overflow_q;
   assign len_mismatch  = mismatch_q;

endmodule

`default_nettype wire
